// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, big-endian byte lanes, sub-word
// stores done as a read-modify-write of the containing word.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// complete immediately with resp_error=1 instead of touching memory).
module load_store_unit #(
  parameter int unsigned addresswidth = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addresswidth-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_error,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [31:0]             mem_data_in,
  input  logic [31:0]             mem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t                  state;
  logic                    lat_write;
  logic [1:0]              lat_size;
  logic                    lat_signed;
  logic [addresswidth-1:0] lat_addr;
  logic [15:0]             lat_wdata;

  logic [addresswidth-1:0] req_word_addr;
  logic [addresswidth-1:0] lat_word_addr;
  logic [31:0]             load_result;
  logic [31:0]             merged_word;
  logic                    misaligned;
  logic [7:0]              sel_byte;
  logic [15:0]             sel_half;

  assign req_word_addr = {2'b00, req_addr[addresswidth-1:2]};
  assign lat_word_addr = {2'b00, lat_addr[addresswidth-1:2]};

  // Ready is a state decode gated by reset so it reads 1 on the first cycle after release
  assign req_ready = (state == IDLE) && !reset;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Extract the addressed lane from the memory word and extend it
  always_comb begin
    sel_byte    = '0;
    sel_half    = '0;
    load_result = '0;
    case (lat_addr[1:0])
      2'd0:    sel_byte = mem_data_out[31:24];
      2'd1:    sel_byte = mem_data_out[23:16];
      2'd2:    sel_byte = mem_data_out[15:8];
      default: sel_byte = mem_data_out[7:0];
    endcase
    sel_half = lat_addr[1] ? mem_data_out[15:0] : mem_data_out[31:16];
    case (lat_size)
      2'b00:   load_result = {{24{lat_signed & sel_byte[7]}}, sel_byte};
      2'b01:   load_result = {{16{lat_signed & sel_half[15]}}, sel_half};
      default: load_result = mem_data_out;
    endcase
  end

  // Replace only the addressed lane of the read word with the store data
  always_comb begin
    merged_word = mem_data_out;
    if (lat_size == 2'b00) begin
      case (lat_addr[1:0])
        2'd0:    merged_word[31:24] = lat_wdata[7:0];
        2'd1:    merged_word[23:16] = lat_wdata[7:0];
        2'd2:    merged_word[15:8]  = lat_wdata[7:0];
        default: merged_word[7:0]   = lat_wdata[7:0];
      endcase
    end else if (lat_size == 2'b01) begin
      if (lat_addr[1]) merged_word[15:0]  = lat_wdata;
      else             merged_word[31:16] = lat_wdata;
    end
  end

  // Control FSM with registered memory and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_size     <= '0;
      lat_signed   <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      mem_address  <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_data_in  <= '0;
    end else begin
      resp_valid   <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata[15:0];
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_size[1]) begin
              state        <= WR;
              mem_write_en <= 1'b1;
              mem_address  <= req_word_addr;
              mem_data_in  <= req_wdata;
            end else begin
              state       <= RD;
              mem_read_en <= 1'b1;
              mem_address <= req_word_addr;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (lat_write) begin
            state        <= WR;
            mem_write_en <= 1'b1;
            mem_address  <= lat_word_addr;
            mem_data_in  <= merged_word;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_result;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Error flag is updated only when a response is produced, so it holds with resp_rdata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_error <= 1'b0;
    end else if ((state == IDLE) && req_valid && misaligned) begin
      resp_error <= 1'b1;
    end else if (((state == CAP) && !lat_write) || (state == WR)) begin
      resp_error <= 1'b0;
    end
  end
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic        mem_write_en, mem_read_en;
  logic [31:0] mem_data_in, mem_data_out;

  logic [31:0] mem [0:63];

  int n_vec  = 0;
  int n_miss = 0;

  int          resp_cyc, rd_cnt, wr_cnt, wr_cyc;
  logic [31:0] got_rdata, wr_addr_seen;
  logic        got_err;

  load_store_unit #(.addresswidth(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[5:0]] <= mem_data_in;
    if (mem_read_en)  mem_data_out <= mem[mem_address[5:0]];
  end

  // Issue one request and record events per cycle after the acceptance edge.
  // req_valid stays high until the response to show it is ignored while busy.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_miss++; $display("FAIL ready_idle got=%b exp=1", req_ready);
    end
    @(posedge clk);
    resp_cyc = -1; rd_cnt = 0; wr_cnt = 0; wr_cyc = -1;
    got_rdata = 'x; got_err = 1'bx; wr_addr_seen = 'x;
    for (int n = 1; n <= 8 && resp_cyc < 0; n++) begin
      @(negedge clk);
      if (mem_read_en) rd_cnt++;
      if (mem_write_en) begin wr_cnt++; wr_cyc = n; wr_addr_seen = mem_address; end
      if (resp_valid) begin
        resp_cyc = n; got_rdata = resp_rdata; got_err = resp_error; req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_vec++;
    if (resp_cyc < 0) begin n_miss++; $display("FAIL resp_timeout no resp_valid in 8 cycles"); end
    @(negedge clk);
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_miss++; $display("FAIL resp_pulse resp_valid=%b req_ready=%b exp 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_error, mem_read_en, mem_write_en} !== 5'b0 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_in !== 32'h0) begin
      n_miss++;
      $display("FAIL reset_outputs ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h din=%h exp all 0",
               req_ready, resp_valid, resp_error, mem_read_en, mem_write_en, resp_rdata, mem_address, mem_data_in);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin n_miss++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
  endtask

  task automatic test_byte_load_signed;
    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    n_vec++;
    if (resp_cyc != 3 || got_rdata !== 32'hFFFFFF99 || rd_cnt != 1 || wr_cnt != 0) begin
      n_miss++; $display("FAIL lb_signed cyc=%0d rdata=%h rd=%0d wr=%0d exp 3/ffffff99/1/0", resp_cyc, got_rdata, rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_rdata_hold;
    repeat (3) @(negedge clk);
    n_vec++;
    if (resp_rdata !== 32'hFFFFFF99 || resp_valid !== 1'b0) begin
      n_miss++; $display("FAIL rdata_hold rdata=%h rv=%b exp ffffff99/0", resp_rdata, resp_valid);
    end
  endtask

  task automatic test_sub_word_loads;
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    n_vec++;
    if (resp_cyc != 3 || got_rdata !== 32'h0000AABB || rd_cnt != 1 || wr_cnt != 0) begin
      n_miss++; $display("FAIL lhu_12 cyc=%0d rdata=%h rd=%0d wr=%0d exp 3/0000aabb/1/0", resp_cyc, got_rdata, rd_cnt, wr_cnt);
    end
    run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    n_vec++;
    if (got_rdata !== 32'hFFFF8899) begin
      n_miss++; $display("FAIL lh_10 rdata=%h exp ffff8899", got_rdata);
    end
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    n_vec++;
    if (got_rdata !== 32'h000000BB) begin
      n_miss++; $display("FAIL lbu_13 rdata=%h exp 000000bb", got_rdata);
    end
    run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    n_vec++;
    if (got_rdata !== 32'h00000088) begin
      n_miss++; $display("FAIL lbu_10 rdata=%h exp 00000088", got_rdata);
    end
  endtask

  task automatic test_misalign;
    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    n_vec++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (resp_cyc != 1 || got_err !== 1'b1 || got_rdata !== 32'h0 || rd_cnt != 0 || wr_cnt != 0) begin
      n_miss++; $display("FAIL lw_misalign cyc=%0d err=%b rdata=%h rd=%0d wr=%0d exp 1/1/0/0/0", resp_cyc, got_err, got_rdata, rd_cnt, wr_cnt);
    end
`else
    if (resp_cyc != 3 || got_err !== 1'b0 || got_rdata !== 32'h8899AABB || rd_cnt != 1) begin
      n_miss++; $display("FAIL lw_unaligned cyc=%0d err=%b rdata=%h rd=%0d exp 3/0/8899aabb/1", resp_cyc, got_err, got_rdata, rd_cnt);
    end
`endif
  endtask

  task automatic test_byte_store;
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC);
    n_vec++;
    if (wr_cnt != 1 || wr_cyc != 3 || resp_cyc != 4 || got_rdata !== 32'h0 || rd_cnt != 1) begin
      n_miss++; $display("FAIL sb_timing wr=%0d wrcyc=%0d resp=%0d rdata=%h rd=%0d exp 1/3/4/0/1", wr_cnt, wr_cyc, resp_cyc, got_rdata, rd_cnt);
    end
    n_vec++;
    if (mem[4] !== 32'h88CCAABB) begin
      n_miss++; $display("FAIL sb_merge mem4=%h exp 88ccaabb", mem[4]);
    end
  endtask

  task automatic test_half_store;
    run_req(1'b1, 2'b01, 1'b0, 32'h1A, 32'hFFFF1234);
    n_vec++;
    if (mem[6] !== 32'h00001234 || resp_cyc != 4) begin
      n_miss++; $display("FAIL sh_merge mem6=%h resp=%0d exp 00001234/4", mem[6], resp_cyc);
    end
  endtask

  task automatic test_word_store;
    run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
    n_vec++;
    if (wr_cnt != 1 || wr_cyc != 1 || wr_addr_seen !== 32'h5 || rd_cnt != 0 || resp_cyc != 2) begin
      n_miss++; $display("FAIL sw_timing wr=%0d wrcyc=%0d addr=%h rd=%0d resp=%0d exp 1/1/5/0/2", wr_cnt, wr_cyc, wr_addr_seen, rd_cnt, resp_cyc);
    end
    n_vec++;
    if (mem[5] !== 32'hDEADBEEF || got_rdata !== 32'h0) begin
      n_miss++; $display("FAIL sw_data mem5=%h rdata=%h exp deadbeef/0", mem[5], got_rdata);
    end
  endtask

  task automatic test_reset_mid_op;
    int wr_seen, rv_seen;
    wr_seen = 0; rv_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_error, mem_read_en, mem_write_en} !== 5'b0 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_in !== 32'h0) begin
      n_miss++;
      $display("FAIL reset_mid_outputs ready=%b rv=%b wr=%b rd=%b rdata=%h addr=%h din=%h exp all 0",
               req_ready, resp_valid, mem_write_en, mem_read_en, resp_rdata, mem_address, mem_data_in);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (mem_write_en) wr_seen++;
      if (resp_valid) rv_seen++;
    end
    n_vec++;
    if (wr_seen != 0 || rv_seen != 0 || mem[4] !== 32'h88CCAABB) begin
      n_miss++; $display("FAIL reset_abandon wr=%0d rv=%0d mem4=%h exp 0/0/88ccaabb", wr_seen, rv_seen, mem[4]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h8899AABB;
    test_reset();
    test_byte_load_signed();
    test_rdata_hold();
    test_sub_word_loads();
    test_misalign();
    test_byte_store();
    test_half_store();
    test_word_store();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: addresswidth, 32, byte-address and memory-address width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: req_valid  input  1  pipeline request present.
REQ-005 SHALL have port: req_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port: req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10/11 word.
REQ-008 SHALL have port: req_signed  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-009 SHALL have port: req_addr  input  addresswidth  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  output  32  load result, valid with resp_valid.
REQ-013 SHALL have port: resp_error  output  1  misaligned access flag, valid with resp_valid.
REQ-014 SHALL have port: mem_address  output  addresswidth  word address to data memory.
REQ-015 SHALL have port: mem_write_en  output  1  data memory write enable.
REQ-016 SHALL have port: mem_read_en  output  1  data memory read enable.
REQ-017 SHALL have port: mem_data_in  output  32  data memory write word.
REQ-018 SHALL have port: mem_data_out  input  32  data memory read word; registered, valid the cycle after read_en is sampled.

Function
REQ-019 SHALL implement FSM states IDLE, RD, CAP, WR, RESP.
REQ-020 SHALL assert req_ready only in IDLE; accept request on clk edge with req_valid&req_ready, latching all req_* fields.
REQ-021 SHALL drive mem_address = {2'b00, latched_addr[addresswidth-1:2]} in RD and WR states; 0 otherwise.
REQ-022 SHALL transition IDLE->WR on accepted word store; IDLE->RD on accepted load or byte/half store.
REQ-023 SHALL assert mem_read_en only in RD; RD->CAP unconditionally.
REQ-024 SHALL in CAP register mem_data_out: load -> compute result, go RESP; sub-word store -> register merged word, go WR.
REQ-025 SHALL use big-endian lanes: byte offset 0 = bits 31:24; half offset 0 = bits 31:16.
REQ-026 SHALL merge sub-word stores by replacing only the addressed lane with req_wdata[7:0] or [15:0], preserving the other lanes.
REQ-027 SHALL assert mem_write_en for exactly one cycle, in WR only, with mem_data_in = store word; mem_data_in = 0 outside WR; WR->RESP.
REQ-028 SHALL assert resp_valid for one cycle in RESP, then return to IDLE; no backpressure on response.
REQ-029 SHALL hold resp_rdata until the next response; store responses return resp_rdata = 0.
REQ-030 SHALL give latencies from acceptance edge: word store resp 2 cycles, load 3, sub-word store 4.
REQ-031 SHALL ignore req_valid outside IDLE (no queuing).

Reset
REQ-032 SHALL on reset asynchronously force IDLE, resp_valid=0, resp_rdata=0, resp_error=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_data_in=0.
REQ-033 SHALL hold req_ready=0 while reset asserted; req_ready=1 in first cycle after release.
REQ-034 SHALL on reset mid-operation abandon the request: no memory write if WR not yet reached, no response issued.

Configuration
REQ-035 SHALL, with LSU_MISALIGN_TRAP_EN defined, detect half with addr[0]=1 or word with addr[1:0]!=0: go IDLE->RESP, no memory enables, resp_error=1, resp_rdata=0.
REQ-036 SHALL, without LSU_MISALIGN_TRAP_EN, tie resp_error=0, ignore addr[0] for halfwords and addr[1:0] for words.

Verification
REQ-037 SHALL verify: word 4 = 0x8899AABB, signed byte load at 0x11 -> resp_valid 3 cycles after accept, resp_rdata=0xFFFFFF99.
REQ-038 SHALL verify: unsigned half load at 0x12 -> resp_rdata=0x0000AABB, mem_read_en high exactly one cycle.
REQ-039 SHALL verify: byte store 0x000000CC at 0x11 -> single mem_write_en at cycle 3, word 4 = 0x88CCAABB, resp_valid at cycle 4.
REQ-040 SHALL verify: word store 0xDEADBEEF at 0x14 -> mem_write_en at cycle 1, mem_address=5, no read_en, resp at cycle 2.
REQ-041 SHALL verify: word load at 0x13 -> macro on: resp_error=1 at cycle 1, no enables; macro off: resp_rdata=0x8899AABB.
REQ-042 SHALL verify: reset asserted during CAP of byte store -> no mem_write_en, word 4 unchanged, all outputs 0.
